// File: rtl/game_pkg.sv
// game_pkg: shared selector FSM encoding and game-level menu state constant
package game_pkg;
  typedef enum logic [1:0] {
    SEL_IDLE   = 2'd0,
    SEL_DELAY  = 2'd1,
    SEL_REPEAT = 2'd2,
    SEL_LOCKED = 2'd3
  } sel_state_e;
  localparam logic [1:0] STATE_MENU = 2'b00;
  function automatic logic is_menu(input logic [1:0] game_state);
    return game_state == STATE_MENU;
  endfunction
endpackage

// File: rtl/btn_edge.sv
// btn_edge: registered rising-edge detector for one debounced button
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);
  logic r_prev;
  // remember last level so a press is only seen on the 0->1 transition
  always_ff @(posedge clk) r_prev <= rst ? 1'b0 : i_btn;
  assign o_press = i_btn & ~r_prev;
endmodule

// File: rtl/menu_selector.sv
// menu_selector: up/down menu index with auto-repeat and confirm lock; MENU_SEL_WRAP_EN selects wrapping bounds
module menu_selector
  import game_pkg::*;
#(
  parameter int WIDTH         = 5,
  parameter int MIN_VAL       = 0,
  parameter int MAX_VAL       = 19,
  parameter int INIT_VAL      = 10,
  parameter int STEP          = 1,
  parameter int REPEAT_DELAY  = 4,
  parameter int REPEAT_PERIOD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic             up,
  input  logic             down,
  input  logic             confirm,
  input  logic             reload,
  output logic [WIDTH-1:0] value,
  output logic             sel_valid,
  output logic [WIDTH-1:0] sel_value,
  output logic             locked
);
  localparam int CMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW = $clog2(CMAX + 1);
  localparam int W1 = WIDTH + 1;
  localparam logic [WIDTH:0] L_MIN = W1'(MIN_VAL);
  localparam logic [WIDTH:0] L_MAX = W1'(MAX_VAL);
  localparam logic [WIDTH:0] L_STEP = W1'(STEP);
  localparam logic [WIDTH:0] L_ONE = W1'(1);
  localparam logic [WIDTH-1:0] L_INIT = WIDTH'(INIT_VAL);
  localparam logic [CW-1:0] L_DLY = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] L_PER = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] L_CONE = CW'(1);
  sel_state_e r_state, w_state_n;
  logic [WIDTH-1:0] r_value, w_value_n, r_sel_value, w_sel_value_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic r_dir, w_dir_n, r_sel_valid, w_sel_valid_n;
  logic w_up_press, w_dn_press, w_cf_press, w_start, w_held, w_tick;
  logic [WIDTH:0] w_val, w_up;
  logic [WIDTH-1:0] w_inc, w_dec, w_step;
  btn_edge u_up (.clk(clk), .rst(rst), .i_btn(up), .o_press(w_up_press));
  btn_edge u_dn (.clk(clk), .rst(rst), .i_btn(down), .o_press(w_dn_press));
  btn_edge u_cf (.clk(clk), .rst(rst), .i_btn(confirm), .o_press(w_cf_press));
  // one extra bit so value+STEP cannot overflow before the bound compare
  assign w_val = {1'b0, r_value};
  assign w_up = w_val + L_STEP;
`ifdef MENU_SEL_WRAP_EN
  assign w_inc = WIDTH'((w_up > L_MAX) ? L_MIN + (w_up - L_MAX - L_ONE) : w_up);
  assign w_dec = WIDTH'((w_val < L_MIN + L_STEP) ? L_MAX - (L_MIN + L_STEP - L_ONE - w_val) : w_val - L_STEP);
`else
  assign w_inc = WIDTH'((w_up > L_MAX) ? L_MAX : w_up);
  assign w_dec = WIDTH'((w_val < L_MIN + L_STEP) ? L_MIN : w_val - L_STEP);
`endif
  assign w_start = (w_up_press & ~down) | (w_dn_press & ~up);
  assign w_step = ((r_state == SEL_IDLE) ? up : r_dir) ? w_inc : w_dec;
  assign w_held = r_dir ? (up & ~down) : (down & ~up);
  assign w_tick = r_cnt == ((r_state == SEL_DELAY) ? L_DLY : L_PER);
  // next state: reload > inactive > locked hold > confirm > stepping
  always_comb begin
    w_state_n = r_state;
    w_value_n = r_value;
    w_cnt_n = r_cnt;
    w_dir_n = r_dir;
    w_sel_value_n = r_sel_value;
    w_sel_valid_n = 1'b0;
    if (reload) begin
      w_value_n = L_INIT;
      w_state_n = SEL_IDLE;
      w_cnt_n = '0;
    end else if (!active) begin
      w_state_n = SEL_IDLE;
      w_cnt_n = '0;
    end else if (r_state != SEL_LOCKED) begin
      if (w_cf_press) begin
        w_sel_value_n = r_value;
        w_sel_valid_n = 1'b1;
        w_state_n = SEL_LOCKED;
        w_cnt_n = '0;
      end else if (r_state == SEL_IDLE) begin
        if (w_start) begin
          w_value_n = w_step;
          w_dir_n = up;
          w_state_n = SEL_DELAY;
          w_cnt_n = '0;
        end
      end else if (!w_held) begin
        w_state_n = SEL_IDLE;
        w_cnt_n = '0;
      end else if (w_tick) begin
        w_value_n = w_step;
        w_state_n = SEL_REPEAT;
        w_cnt_n = '0;
      end else begin
        w_cnt_n = r_cnt + L_CONE;
      end
    end
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEL_IDLE;
      r_value <= L_INIT;
      r_cnt <= '0;
      r_dir <= 1'b0;
      r_sel_value <= L_INIT;
      r_sel_valid <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_value <= w_value_n;
      r_cnt <= w_cnt_n;
      r_dir <= w_dir_n;
      r_sel_value <= w_sel_value_n;
      r_sel_valid <= w_sel_valid_n;
    end
  end
  assign value = r_value;
  assign sel_value = r_sel_value;
  assign sel_valid = r_sel_valid;
  assign locked = r_state == SEL_LOCKED;
endmodule

// File: tb/tb_menu_selector.sv
// tb_menu_selector: directed plus random stimulus against a held-cycle-count reference model
module tb_menu_selector;
  localparam int MINV = 0, MAXV = 19, INIT = 10, STEP = 1, DLY = 4, PER = 1;
  localparam int RNG = MAXV - MINV + 1;
  logic clk = 1'b0;
  logic rst = 1'b0, active = 1'b0, up = 1'b0, down = 1'b0, confirm = 1'b0, reload = 1'b0;
  logic [4:0] value, sel_value;
  logic sel_valid, locked;
  int vectors = 0, miscompares = 0;
  int m_val, m_sel, m_sv, m_lock, m_held, m_k, saved;
  bit m_pu, m_pd, m_pc;
  always #5 clk = ~clk;
  menu_selector #(
    .WIDTH(5), .MIN_VAL(MINV), .MAX_VAL(MAXV), .INIT_VAL(INIT),
    .STEP(STEP), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) dut (
    .clk(clk), .rst(rst), .active(active), .up(up), .down(down),
    .confirm(confirm), .reload(reload), .value(value),
    .sel_valid(sel_valid), .sel_value(sel_value), .locked(locked)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int stp(input int v, input bit go_up);
`ifdef MENU_SEL_WRAP_EN
    return go_up ? ((v - MINV + STEP) % RNG) + MINV : ((v - MINV - STEP + RNG) % RNG) + MINV;
`else
    return go_up ? ((v + STEP > MAXV) ? MAXV : v + STEP) : ((v - STEP < MINV) ? MINV : v - STEP);
`endif
  endfunction
  task automatic model_step();
    bit pu, pd, pc;
    pu = up & ~m_pu;
    pd = down & ~m_pd;
    pc = confirm & ~m_pc;
    m_sv = 0;
    if (reload) begin
      m_val = INIT; m_lock = 0; m_held = 0;
    end else if (!active) begin
      m_lock = 0; m_held = 0;
    end else if (!m_lock) begin
      if (pc) begin
        m_sel = m_val; m_sv = 1; m_lock = 1; m_held = 0;
      end else if (m_held == 0) begin
        if (pu && !down) begin m_val = stp(m_val, 1); m_held = 1; m_k = 0; end
        else if (pd && !up) begin m_val = stp(m_val, 0); m_held = 2; m_k = 0; end
      end else if (m_held == 1 ? (!up || down) : (!down || up)) begin
        m_held = 0;
      end else begin
        m_k++;
        if (m_k == DLY || (m_k > DLY && (m_k - DLY) % PER == 0)) m_val = stp(m_val, m_held == 1);
      end
    end
    m_pu = up; m_pd = down; m_pc = confirm;
  endtask
  task automatic compare_all();
    check("value", value, m_val);
    check("sel_valid", sel_valid, m_sv);
    check("sel_value", sel_value, m_sel);
    check("locked", locked, m_lock);
  endtask
  task automatic tick(input bit u, input bit d, input bit c, input bit a, input bit r);
    up = u; down = d; confirm = c; active = a; reload = r;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask
  task automatic press_up();
    tick(1, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0);
  endtask
  task automatic press_dn();
    tick(0, 1, 0, 1, 0);
    tick(0, 0, 0, 1, 0);
  endtask
  initial begin
    bit ru = 0, rd = 0, ra = 1;
    rst = 1'b1;
    @(posedge clk);
    m_val = INIT; m_sel = INIT; m_sv = 0; m_lock = 0; m_held = 0; m_k = 0;
    m_pu = 0; m_pd = 0; m_pc = 0;
    #1;
    check("rst_value", value, 10);
    check("rst_locked", locked, 0);
    check("rst_sel_valid", sel_valid, 0);
    check("rst_sel_value", sel_value, 10);
    rst = 1'b0;
    repeat (3) press_up();
    check("three_up", value, 13);
    tick(0, 0, 0, 1, 1);
    for (int i = 0; i < 20; i++) begin
      tick(0, 1, 0, 1, 0);
      if (i == 0) check("hold_first", value, 9);
      if (i == 3) check("hold_delay", value, 9);
      if (i == 4) check("hold_repeat", value, 8);
    end
`ifdef MENU_SEL_WRAP_EN
    check("hold_20", value, 13);
`else
    check("hold_20", value, 0);
`endif
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 1);
    repeat (9) press_up();
    check("at_max", value, 19);
    press_up();
`ifdef MENU_SEL_WRAP_EN
    check("up_at_max", value, 0);
`else
    check("up_at_max", value, 19);
    tick(0, 0, 0, 1, 1);
    repeat (15) tick(0, 1, 0, 1, 0);
    tick(0, 0, 0, 1, 0);
    check("at_min", value, 0);
`endif
    press_dn();
`ifdef MENU_SEL_WRAP_EN
    check("dn_at_min", value, 19);
`else
    check("dn_at_min", value, 0);
`endif
    tick(0, 0, 0, 1, 1);
    repeat (3) press_dn();
    tick(1, 0, 1, 1, 0);
    check("cf_valid", sel_valid, 1);
    check("cf_sel", sel_value, 7);
    check("cf_value", value, 7);
    check("cf_locked", locked, 1);
    tick(1, 0, 0, 1, 0);
    check("cf_pulse", sel_valid, 0);
    tick(0, 0, 0, 1, 0);
    press_up();
    check("locked_hold", value, 7);
    tick(0, 0, 0, 1, 1);
    repeat (7) tick(1, 0, 0, 1, 0);
    saved = m_val;
    repeat (3) tick(1, 0, 0, 0, 0);
    check("inact_hold", value, saved);
    check("inact_unlock", locked, 0);
    repeat (6) tick(1, 0, 0, 1, 0);
    check("reenter_nostep", value, saved);
    tick(0, 0, 0, 1, 0);
    press_up();
    check("reenter_press", value, saved + 1);
    saved = m_val;
    tick(1, 1, 0, 1, 0);
    check("both", value, saved);
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 1);
    repeat (5) press_up();
    tick(0, 0, 1, 1, 0);
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 1);
    check("reload_value", value, 10);
    check("reload_unlock", locked, 0);
    check("reload_sel", sel_value, 15);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 10) ru = ~ru;
      if ($urandom_range(0, 99) < 10) rd = ~rd;
      if ($urandom_range(0, 99) < 3) ra = ~ra;
      tick(ru, rd, $urandom_range(0, 99) < 4, ra, $urandom_range(0, 99) < 2);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
